// File: rtl/jk_updown_counter_pkg.sv
// Shared JK definitions: cell command encoding and the excitation helper.
// Used by jk_updown_counter and jk_cell.
package jk_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'b00,
        CLR  = 2'b01,
        SET  = 2'b10,
        TGL  = 2'b11
    } jk_cmd_t;

    // {J,K} needed to move one cell from q_bit to next_bit
    function automatic jk_cmd_t jk_excite(input logic q_bit,
                                          input logic next_bit);
        return jk_cmd_t'({next_bit & ~q_bit, ~next_bit & q_bit});
    endfunction

endpackage

// File: rtl/jk_updown_counter_if.sv
// Control/status bundle of the JK up/down counter.
// master drives en/up/load/load_val; slave returns q/tc/j_out/k_out.
interface jk_updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic [WIDTH-1:0] j_out;
    logic [WIDTH-1:0] k_out;

    modport master (
        output en, up, load, load_val,
        input  q, tc, j_out, k_out
    );

    modport slave (
        input  en, up, load, load_val,
        output q, tc, j_out, k_out
    );
endinterface

// File: rtl/jk_updown_counter_cell.sv
// One-bit JK flip-flop, async active-high clear.
// {J,K}: 00 hold, 01 clear, 10 set, 11 toggle.
module jk_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);

    logic q_q;

    // JK state update on the rising edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= 1'b0;
        end else begin
            unique case (jk_cmd_t'({j, k}))
                HOLD: q_q <= q_q;
                CLR:  q_q <= 1'b0;
                SET:  q_q <= 1'b1;
                TGL:  q_q <= ~q_q;
            endcase
        end
    end

    assign q = q_q;

endmodule

// File: rtl/jk_updown_counter.sv
// Modulo-MODULUS up/down counter built on a bank of JK cells.
// Define JK_UPDOWN_COUNTER_SATURATE_EN to saturate instead of wrap.
module jk_updown_counter
    import jk_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input logic                 clk,
    input logic                 rst,
    jk_updown_counter_if.slave  bus
);

    generate
        if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_mod
            $error("jk_updown_counter: MODULUS out of range 2..2**WIDTH");
        end
    endgenerate

`ifdef JK_UPDOWN_COUNTER_SATURATE_EN
    localparam logic WRAP = 1'b0;
`else
    localparam logic WRAP = 1'b1;
`endif

    localparam logic [WIDTH:0] MOD_X = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0] MAX_X = (WIDTH+1)'(MODULUS - 1);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] next_d;
    logic [WIDTH:0]   q_x;
    logic [WIDTH:0]   lv_x;
    logic [WIDTH:0]   nxt_x;
    logic [WIDTH-1:0] j_d;
    logic [WIDTH-1:0] k_d;
    logic             tc;
    logic             unused_msb;

    // One extra bit keeps +1 and compares exact at MODULUS = 2**WIDTH
    assign q_x  = {1'b0, q_q};
    assign lv_x = {1'b0, bus.load_val};

    // Next-state select: load, then count up, then count down, else hold
    always_comb begin
        nxt_x = q_x;
        unique case (1'b1)
            bus.load: begin
                nxt_x = (lv_x >= MOD_X) ? MAX_X : lv_x;
            end
            (!bus.load && bus.en && bus.up): begin
                if (q_x == MAX_X) nxt_x = WRAP ? '0 : q_x;
                else              nxt_x = q_x + 1'b1;
            end
            (!bus.load && bus.en && !bus.up): begin
                if (q_x == '0) nxt_x = WRAP ? MAX_X : q_x;
                else           nxt_x = q_x - 1'b1;
            end
            default: ;
        endcase
    end

    // Next value always lies below MODULUS, so the top bit is zero
    assign next_d     = nxt_x[WIDTH-1:0];
    assign unused_msb = nxt_x[WIDTH];

    // Per-bit J/K excitation from current and next state
    always_comb begin
        jk_cmd_t cmd;
        cmd = HOLD;
        j_d = '0;
        k_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cmd    = jk_excite(q_q[i], next_d[i]);
            j_d[i] = cmd[1];
            k_d[i] = cmd[0];
        end
    end

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cell
            jk_cell u_cell (
                .clk (clk),
                .rst (rst),
                .j   (j_d[i]),
                .k   (k_d[i]),
                .q   (q_q[i])
            );
        end
    endgenerate

    // Terminal count: the cycle before a wrap (or a saturating hold)
    assign tc = bus.en & ~bus.load &
                ((bus.up & (q_x == MAX_X)) | (~bus.up & (q_x == '0)));

    assign bus.q     = q_q;
    assign bus.tc    = tc;
    assign bus.j_out = j_d;
    assign bus.k_out = k_d;

endmodule

// File: tb/tb_jk_updown_counter.sv
// Self-checking bench for jk_updown_counter (WIDTH=4, MODULUS=10).
// Directed sequences plus random traffic against an arithmetic model.
module tb_jk_updown_counter;

    localparam int W    = 4;
    localparam int MOD  = 10;
    localparam int MASK = (1 << W) - 1;
`ifdef JK_UPDOWN_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   m      = 0;

    jk_updown_counter_if #(.WIDTH(W)) bus ();

    jk_updown_counter #(.WIDTH(W), .MODULUS(MOD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model_next(input int cur, input bit e,
                                      input bit u, input bit l,
                                      input int lv);
        if (l) return (lv >= MOD) ? MOD - 1 : lv;
        if (!e) return cur;
        if (u) return (cur == MOD - 1) ? (SAT ? cur : 0) : cur + 1;
        return (cur == 0) ? (SAT ? 0 : MOD - 1) : cur - 1;
    endfunction

    task automatic step(input bit e, input bit u, input bit l,
                        input int lv);
        int nx;
        bit tce;
        @(negedge clk);
        bus.en = e;
        bus.up = u;
        bus.load = l;
        bus.load_val = W'(lv);
        #1;
        nx  = model_next(m, e, u, l, lv);
        tce = e && !l && ((u && m == MOD - 1) || (!u && m == 0));
        check("tc", 32'(bus.tc), 32'(tce));
        check("j_out", 32'(bus.j_out), 32'(nx & ~m & MASK));
        check("k_out", 32'(bus.k_out), 32'(~nx & m & MASK));
        @(posedge clk);
        #1;
        m = nx;
        check("q", 32'(bus.q), 32'(m));
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        bus.en = 1'b0;
        bus.load = 1'b0;
        #2 rst = 1'b1;
        #1;
        m = 0;
        check("rst_q", 32'(bus.q), 0);
        check("rst_j", 32'(bus.j_out), 0);
        check("rst_k", 32'(bus.k_out), 0);
        check("rst_tc", 32'(bus.tc), 0);
        #1 rst = 1'b0;
    endtask

    initial begin
        bus.en = 1'b0;
        bus.up = 1'b0;
        bus.load = 1'b0;
        bus.load_val = '0;
        repeat (2) @(negedge clk);
        check("init_q", 32'(bus.q), 0);
        check("init_tc", 32'(bus.tc), 0);
        rst = 1'b0;

        step(0, 0, 1, 7);
        check("pre_rst_q", 32'(bus.q), 7);
        pulse_rst();

        for (int i = 0; i < 12; i++) step(1, 1, 0, 0);
        step(0, 0, 1, 2);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);

        step(1, 1, 1, 5);
        check("load5_q", 32'(bus.q), 5);
        step(1, 1, 1, 13);
        check("clamp_q", 32'(bus.q), 9);

        step(0, 0, 1, 3);
        for (int i = 0; i < 5; i++) step(0, i[0], 0, 0);
        check("hold_q", 32'(bus.q), 3);

        step(0, 0, 1, 8);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
        step(0, 0, 1, 1);
        for (int i = 0; i < 2; i++) step(1, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(39) == 0) begin
                pulse_rst();
            end else begin
                step(bit'($urandom_range(3) != 0), bit'($urandom_range(1)),
                     bit'($urandom_range(7) == 0),
                     int'($urandom_range(MASK)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
